// File: rtl/icap_reg_reader.sv
// icap_reg_reader: ZX-Uno register front-end that reads one 7-series config register through ICAPE2
// and serves the 32-bit result to the host a byte at a time.
module icap_reg_reader #(
   parameter logic [7:0] ADDR_ICAPCTRL = 8'hFE,
   parameter logic [7:0] ADDR_ICAPDATA = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  zxuno_addr,
   input  logic        regaddr_changed,
   input  logic        zxuno_regrd,
   input  logic        zxuno_regwr,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   output logic        oe,
   output logic        icap_csib,
   output logic        icap_rdwrb,
   output logic [31:0] icap_i,
   input  logic [31:0] icap_o
);
   typedef enum logic [2:0] {IDLE, WRITE_HDR, TO_READ, READ, TO_WRITE, DESYNC} state_t;
   state_t      r_state;
   logic [2:0]  r_step;
   logic        r_busy;
   logic [1:0]  r_sel;
   logic [1:0]  r_chunk;
   logic [31:0] r_data;
   logic [7:0]  r_byte;
   logic        r_wr_d;
   logic        r_rd_d;
   logic [2:0]  w_nstep;
   logic [31:0] w_hdr;
   logic [31:0] w_seq_word;
   logic [31:0] w_des_word;
   logic        w_trig;
   logic        w_rd_edge;
   logic        w_ctrl;
   logic        w_dat;
   logic        w_unused;
   assign w_unused   = ^din[7:2];
   assign w_nstep    = r_step + 3'd1;
   assign w_hdr      = r_sel == 2'd0 ? 32'h2800E001 :
                       r_sel == 2'd1 ? 32'h2802C001 :
                       r_sel == 2'd2 ? 32'h28020001 : 32'h28018001;
   // Word sent on the cycle after the current step; step 0 words are loaded on entry.
   assign w_seq_word = w_nstep == 3'd1 ? 32'hAA995566 :
                       w_nstep == 3'd3 ? w_hdr : 32'h20000000;
   assign w_des_word = w_nstep == 3'd1 ? 32'h0000000D : 32'h20000000;
   assign w_ctrl     = zxuno_addr == ADDR_ICAPCTRL && zxuno_regrd;
   assign w_dat      = zxuno_addr == ADDR_ICAPDATA && zxuno_regrd;
   assign w_trig     = zxuno_addr == ADDR_ICAPCTRL && zxuno_regwr && !r_wr_d && r_state == IDLE;
   assign w_rd_edge  = w_dat && !r_rd_d;
   assign oe         = w_ctrl || w_dat;
   assign dout       = w_ctrl ? {r_busy, 5'b0, r_sel} : w_dat ? r_byte : 8'hFF;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_step     <= 3'd0;
         r_busy     <= 1'b0;
         icap_csib  <= 1'b1;
         icap_rdwrb <= 1'b0;
         icap_i     <= 32'hFFFFFFFF;
         r_sel      <= 2'd0;
         r_data     <= 32'd0;
         r_byte     <= 8'd0;
         r_chunk    <= 2'd0;
         r_wr_d     <= 1'b0;
         r_rd_d     <= 1'b0;
      end else begin
         r_wr_d <= zxuno_regwr;
         r_rd_d <= zxuno_regrd;
         if (w_rd_edge) begin
            r_byte  <= r_data[{~r_chunk, 3'b000} +: 8];
            r_chunk <= r_chunk + 2'd1;
         end
         if (regaddr_changed && zxuno_addr == ADDR_ICAPDATA)
            r_chunk <= 2'd0;
         case (r_state)
            IDLE:
               if (w_trig) begin
                  r_state   <= WRITE_HDR;
                  r_step    <= 3'd0;
                  r_busy    <= 1'b1;
                  icap_csib <= 1'b0;
                  icap_rdwrb <= 1'b0;
                  icap_i    <= 32'hFFFFFFFF;
                  r_sel     <= din[1:0];
               end
            WRITE_HDR:
               if (r_step == 3'd5) begin
                  r_state    <= TO_READ;
                  icap_csib  <= 1'b1;
                  icap_rdwrb <= 1'b1;
               end else begin
                  r_step <= w_nstep;
                  icap_i <= w_seq_word;
               end
            TO_READ: begin
               r_state   <= READ;
               r_step    <= 3'd0;
               icap_csib <= 1'b0;
            end
            READ:
               if (r_step == 3'd3) begin
                  r_state   <= TO_WRITE;
                  r_step    <= 3'd0;
                  icap_csib <= 1'b1;
                  r_data    <= icap_o;
                  r_chunk   <= 2'd0;
               end else
                  r_step <= w_nstep;
            TO_WRITE:
               if (r_step == 3'd0) begin
                  r_step     <= 3'd1;
                  icap_rdwrb <= 1'b0;
               end else begin
                  r_state   <= DESYNC;
                  r_step    <= 3'd0;
                  icap_csib <= 1'b0;
                  icap_i    <= 32'h30008001;
               end
            DESYNC:
               if (r_step == 3'd3) begin
                  r_state   <= IDLE;
                  r_busy    <= 1'b0;
                  icap_csib <= 1'b1;
                  icap_i    <= 32'hFFFFFFFF;
               end else begin
                  r_step <= w_nstep;
                  icap_i <= w_des_word;
               end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_icap_reg_reader.sv
// tb_icap_reg_reader: scoreboard bench; stimulus queues expected ICAP cycles and read bytes,
// two monitors pop and compare as the DUT drives csib low or a read strobe ends.
module tb_icap_reg_reader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  zxuno_addr = 8'h00;
   logic        regaddr_changed = 1'b0;
   logic        zxuno_regrd = 1'b0;
   logic        zxuno_regwr = 1'b0;
   logic [7:0]  din = 8'h00;
   logic [7:0]  dout;
   logic        oe;
   logic        icap_csib;
   logic        icap_rdwrb;
   logic [31:0] icap_i;
   logic [31:0] icap_o;
   logic [31:0] icap_word = 32'h0;

   typedef struct {logic csib; logic rdwrb; logic chk; logic [31:0] w; int k; bit last;} ie_t;
   typedef struct {logic oe; logic [7:0] d; int id;} re_t;
   ie_t iq[$];
   re_t rq[$];
   int total = 0, bad = 0, rid = 0;
   logic [31:0] hdr [4] = '{32'h2800E001, 32'h2802C001, 32'h28020001, 32'h28018001};
   int          m_chunk = 0;
   logic [31:0] m_word = 32'h0;
   logic [1:0]  m_sel = 2'd0;
   logic        m_busy = 1'b0;

   icap_reg_reader dut (
      .clk(clk), .rst(rst), .zxuno_addr(zxuno_addr), .regaddr_changed(regaddr_changed),
      .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr), .din(din), .dout(dout), .oe(oe),
      .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i), .icap_o(icap_o)
   );

   always #5 clk = ~clk;
   // The ICAP only presents readback data while selected for reading.
   assign icap_o = (!icap_csib && icap_rdwrb) ? icap_word : 32'hA5C33C5A;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic push_icap(input logic [1:0] s);
      for (int k = 1; k <= 18; k++) begin
         ie_t e;
         e.k = k; e.last = (k == 18); e.chk = 1'b0; e.w = 32'h0;
         if (k <= 6) begin
            e.csib = 0; e.rdwrb = 0; e.chk = 1;
            e.w = k == 1 ? 32'hFFFFFFFF : k == 2 ? 32'hAA995566 : k == 4 ? hdr[s] : 32'h20000000;
         end else if (k == 7 || k == 12) begin
            e.csib = 1; e.rdwrb = 1;
         end else if (k <= 11) begin
            e.csib = 0; e.rdwrb = 1;
         end else if (k == 13) begin
            e.csib = 1; e.rdwrb = 0;
         end else if (k <= 17) begin
            e.csib = 0; e.rdwrb = 0; e.chk = 1;
            e.w = k == 14 ? 32'h30008001 : k == 15 ? 32'h0000000D : 32'h20000000;
         end else begin
            e.csib = 1; e.rdwrb = 0; e.chk = 1; e.w = 32'hFFFFFFFF;
         end
         iq.push_back(e);
      end
   endtask

   task automatic rd(input logic [7:0] addr, input int n);
      re_t e;
      e.id = rid++;
      if (addr == 8'hFF) begin
         e.oe = 1; e.d = m_word[8*(3-m_chunk) +: 8]; m_chunk = (m_chunk + 1) % 4;
      end else if (addr == 8'hFE) begin
         e.oe = 1; e.d = {m_busy, 5'b0, m_sel};
      end else begin
         e.oe = 0; e.d = 8'hFF;
      end
      rq.push_back(e);
      zxuno_addr = addr;
      zxuno_regrd = 1;
      repeat (n) step();
      zxuno_regrd = 0;
      step();
   endtask

   task automatic start_seq(input logic [7:0] d, input logic [31:0] w);
      push_icap(d[1:0]);
      icap_word = w; m_sel = d[1:0]; m_busy = 1;
      zxuno_addr = 8'hFE; din = d; zxuno_regwr = 1;
      step();
      zxuno_regwr = 0;
   endtask

   // mode 0: plain, 1: data read while busy, 2: second control write at T+5
   task automatic run_seq(input logic [7:0] d, input logic [31:0] w, input int mode);
      int c;
      start_seq(d, w);
      c = 1;
      if (mode == 1) begin
         rd(8'hFF, 2);
         c += 3;
      end else if (mode == 2) begin
         repeat (4) step();
         zxuno_addr = 8'hFE; din = 8'h02; zxuno_regwr = 1;
         step();
         zxuno_regwr = 0;
         c = 6;
      end
      repeat (16 - c) step();
      rd(8'hFE, 1);
      m_busy = 0; m_word = w; m_chunk = 0;
      rd(8'hFE, 1);
   endtask

   ie_t ie;
   bit  in_seq = 0;
   always @(negedge clk) begin
      if (rst) begin
         iq.delete();
         in_seq = 0;
      end else if (in_seq || !icap_csib) begin
         total++;
         if (iq.size() == 0) begin
            bad++;
            $display("FAIL icap_unexpected csib=%b rdwrb=%b icap_i=%h", icap_csib, icap_rdwrb, icap_i);
         end else begin
            ie = iq.pop_front();
            in_seq = !ie.last;
            if (icap_csib !== ie.csib || icap_rdwrb !== ie.rdwrb || (ie.chk && icap_i !== ie.w)) begin
               bad++;
               $display("FAIL icap_T+%0d got csib=%b rdwrb=%b i=%h exp csib=%b rdwrb=%b i=%h",
                        ie.k, icap_csib, icap_rdwrb, icap_i, ie.csib, ie.rdwrb, ie.w);
            end
         end
      end
   end

   re_t        re;
   logic       s_oe;
   logic [7:0] s_d;
   bit         prev_rd = 0;
   always @(negedge clk) begin
      if (zxuno_regrd) begin
         s_oe = oe; s_d = dout;
      end else if (prev_rd) begin
         total++;
         if (rq.size() == 0) begin
            bad++;
            $display("FAIL rd_unexpected oe=%b dout=%h", s_oe, s_d);
         end else begin
            re = rq.pop_front();
            if (s_oe !== re.oe || s_d !== re.d) begin
               bad++;
               $display("FAIL read#%0d got oe=%b dout=%h exp oe=%b dout=%h", re.id, s_oe, s_d, re.oe, re.d);
            end
         end
      end
      prev_rd = zxuno_regrd;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      rst = 0;
      chk("rst_csib", {31'b0, icap_csib}, 32'd1);
      chk("rst_rdwrb", {31'b0, icap_rdwrb}, 32'd0);
      chk("rst_icap_i", icap_i, 32'hFFFFFFFF);
      rd(8'hFE, 1);
      rd(8'hFF, 2);
      run_seq(8'h03, 32'h0362D093, 0);
      repeat (5) rd(8'hFF, 2);
      run_seq(8'h01, 32'h00000001, 1);
      rd(8'hFE, 1);
      repeat (4) rd(8'hFF, 2);
      run_seq(8'h03, 32'h89ABCDEF, 2);
      rd(8'hFF, 2);
      rd(8'hFF, 2);
      zxuno_addr = 8'hFF; regaddr_changed = 1;
      step();
      regaddr_changed = 0; m_chunk = 0;
      rd(8'hFF, 2);
      rd(8'hFF, 10);
      rd(8'hFF, 2);
      rd(8'h40, 2);
      start_seq(8'h03, 32'h12345678);
      repeat (8) step();
      rst = 1;
      step();
      rst = 0;
      m_busy = 0; m_sel = 0; m_word = 0; m_chunk = 0;
      chk("abort_csib", {31'b0, icap_csib}, 32'd1);
      chk("abort_rdwrb", {31'b0, icap_rdwrb}, 32'd0);
      chk("abort_icap_i", icap_i, 32'hFFFFFFFF);
      rd(8'hFE, 1);
      rd(8'hFF, 2);
      run_seq(8'h02, 32'hCAFEF00D, 0);
      repeat (4) rd(8'hFF, 2);
      for (int it = 0; it < 8; it++) begin
         run_seq(8'($urandom), $urandom, int'($urandom_range(0, 1)));
         for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
            if ($urandom_range(0, 3) == 0) begin
               zxuno_addr = 8'hFF; regaddr_changed = 1;
               step();
               regaddr_changed = 0; m_chunk = 0;
            end
            rd(8'hFF, int'($urandom_range(2, 4)));
         end
         rd(8'hFE, 1);
         rd(8'($urandom_range(0, 253)), 2);
      end
      repeat (3) step();
      chk("icap_queue_left", 32'(iq.size()), 32'd0);
      chk("read_queue_left", 32'(rq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
